// File: rtl/z80_refresh_unit_pkg.sv
// Shared Z80 definitions for the refresh unit: the refresh FSM state type and the R increment mask.
package z80_refresh_unit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RFSH = 1'b1
   } rfsh_state_t;

   localparam logic [7:0] R_INC_MASK = 8'h7F;

   // R[6:0] counts modulo 128; R[7] is left as written by LD R,A.
   function automatic logic [7:0] r_increment(input logic [7:0] r);
      return ((r + 8'd1) & R_INC_MASK) | (r & ~R_INC_MASK);
   endfunction

endpackage

// File: rtl/z80_refresh_unit_if.sv
// Bus between the CPU core and the refresh unit. z80fi_reg_r_in exists only when Z80FI_TRACE_EN is defined.
interface z80_refresh_unit_if;

   logic        refresh_start;
   logic [7:0]  reg_i;
   logic        r_write;
   logic [7:0]  r_wdata;
   logic        insn_start;
   logic [7:0]  reg_r;
   logic        refresh_active;
   logic [15:0] refresh_addr;
`ifdef Z80FI_TRACE_EN
   logic [7:0]  z80fi_reg_r_in;
`endif

   modport master (
      output refresh_start, reg_i, r_write, r_wdata, insn_start,
      input  reg_r, refresh_active, refresh_addr
`ifdef Z80FI_TRACE_EN
      , input z80fi_reg_r_in
`endif
   );

   modport slave (
      input  refresh_start, reg_i, r_write, r_wdata, insn_start,
      output reg_r, refresh_active, refresh_addr
`ifdef Z80FI_TRACE_EN
      , output z80fi_reg_r_in
`endif
   );

endinterface

// File: rtl/z80_refresh_unit_timer.sv
// Refresh window timer: IDLE/RFSH state plus a 3-bit cycle counter; start is ignored while a window runs.
module z80_refresh_timer
   import z80_refresh_unit_pkg::*;
#(
   parameter int unsigned REFRESH_TCYCLES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   output logic active,
   output logic last
);

   localparam logic [2:0] LAST_CNT = 3'(REFRESH_TCYCLES - 1);

   rfsh_state_t state, next_state;
   logic [2:0]  cnt, next_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      active     = 1'b0;
      last       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               next_state = RFSH;
               next_cnt   = '0;
            end
         end
         RFSH: begin
            active = 1'b1;
            if (cnt == LAST_CNT) begin
               last       = 1'b1;
               next_state = IDLE;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + 3'd1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: rtl/z80_refresh_unit.sv
// Z80 memory refresh unit: owns R, drives the {I,R} refresh address for a fixed window after each M1 T3.
// Optional instruction-start trace of R is enabled by defining Z80FI_TRACE_EN.
module z80_refresh_unit
   import z80_refresh_unit_pkg::*;
#(
   parameter int unsigned REFRESH_TCYCLES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   z80_refresh_unit_if.slave  bus
);

   logic        active;
   logic        last;
   logic        accept;
   logic [7:0]  r_q;
   logic [7:0]  r_latch;
   logic [7:0]  i_latch;

   z80_refresh_timer #(
      .REFRESH_TCYCLES(REFRESH_TCYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (bus.refresh_start),
      .active  (active),
      .last    (last)
   );

   assign accept = bus.refresh_start && !active;

   // The address latch is only loaded on an accepted start, so LD R,A mid-window cannot disturb it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_latch <= '0;
         i_latch <= '0;
      end else if (accept) begin
         r_latch <= r_q;
         i_latch <= bus.reg_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= '0;
      end else if (bus.r_write) begin
         r_q <= bus.r_wdata;
      end else if (last) begin
         r_q <= r_increment(r_q);
      end
   end

`ifdef Z80FI_TRACE_EN
   logic [7:0] trace_r;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trace_r <= '0;
      end else if (bus.insn_start) begin
         trace_r <= r_q;
      end
   end

   assign bus.z80fi_reg_r_in = trace_r;
`else
   logic unused_insn_start;
   assign unused_insn_start = bus.insn_start;
`endif

   assign bus.reg_r          = r_q;
   assign bus.refresh_active = active;
   assign bus.refresh_addr   = {i_latch, r_latch};

endmodule

// File: tb/tb_z80_refresh_unit.sv
// Directed self-checking bench for z80_refresh_unit; trace checks compile in when Z80FI_TRACE_EN is defined.
module tb_z80_refresh_unit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   z80_refresh_unit_if bus();

   z80_refresh_unit #(
      .REFRESH_TCYCLES(2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_r(input logic [7:0] v);
      bus.r_write = 1'b1;
      bus.r_wdata = v;
      tick();
      bus.r_write = 1'b0;
   endtask

   task automatic pulse_start(input logic [7:0] i);
      bus.refresh_start = 1'b1;
      bus.reg_i = i;
      tick();
      bus.refresh_start = 1'b0;
      bus.reg_i = 8'hEE;
   endtask

   // Full window from current R, checking the 2-cycle window and the incremented result.
   task automatic refresh_window(input string tag, input logic [7:0] i, input logic [7:0] r,
                                 input logic [7:0] r_next);
      pulse_start(i);
      check({tag, " act1"}, {15'd0, bus.refresh_active}, 16'd1);
      check({tag, " addr1"}, bus.refresh_addr, {i, r});
      tick();
      check({tag, " act2"}, {15'd0, bus.refresh_active}, 16'd1);
      check({tag, " addr2"}, bus.refresh_addr, {i, r});
      check({tag, " r_hold"}, {8'd0, bus.reg_r}, {8'd0, r});
      tick();
      check({tag, " act_end"}, {15'd0, bus.refresh_active}, 16'd0);
      check({tag, " r_inc"}, {8'd0, bus.reg_r}, {8'd0, r_next});
   endtask

   initial begin
      bus.refresh_start = 1'b0;
      bus.reg_i = 8'h00;
      bus.r_write = 1'b0;
      bus.r_wdata = 8'h00;
      bus.insn_start = 1'b0;
      #12;
      check("rst reg_r", {8'd0, bus.reg_r}, 16'h0000);
      check("rst active", {15'd0, bus.refresh_active}, 16'd0);
      check("rst addr", bus.refresh_addr, 16'h0000);
`ifdef Z80FI_TRACE_EN
      check("rst trace", {8'd0, bus.z80fi_reg_r_in}, 16'h0000);
`endif
      reset_n = 1'b1;
      tick();

      write_r(8'h05);
      check("write 05", {8'd0, bus.reg_r}, 16'h0005);
      refresh_window("basic", 8'h12, 8'h05, 8'h06);

      write_r(8'h7F);
      refresh_window("wrap7f", 8'hA5, 8'h7F, 8'h00);
      write_r(8'hFF);
      refresh_window("wrapff", 8'h3C, 8'hFF, 8'h80);

      // Collision: LD R,A on the increment edge wins.
      write_r(8'h10);
      pulse_start(8'h55);
      check("coll addr1", bus.refresh_addr, 16'h5510);
      tick();
      bus.r_write = 1'b1;
      bus.r_wdata = 8'h40;
      check("coll addr2", bus.refresh_addr, 16'h5510);
      tick();
      bus.r_write = 1'b0;
      check("coll reg_r", {8'd0, bus.reg_r}, 16'h0040);
      check("coll addr_after", bus.refresh_addr, 16'h5510);
      check("coll act", {15'd0, bus.refresh_active}, 16'd0);

      // Write during the first window cycle leaves the address latch alone.
      write_r(8'h08);
      pulse_start(8'h77);
      bus.r_write = 1'b1;
      bus.r_wdata = 8'h30;
      tick();
      bus.r_write = 1'b0;
      check("midwr addr", bus.refresh_addr, 16'h7708);
      check("midwr reg_r", {8'd0, bus.reg_r}, 16'h0030);
      tick();
      check("midwr inc", {8'd0, bus.reg_r}, 16'h0031);

      // Back-to-back: start during RFSH ignored, start right after IDLE accepted.
      write_r(8'h20);
      pulse_start(8'h01);
      bus.refresh_start = 1'b1;
      tick();
      bus.refresh_start = 1'b0;
      check("b2b act2", {15'd0, bus.refresh_active}, 16'd1);
      tick();
      check("b2b act_end", {15'd0, bus.refresh_active}, 16'd0);
      check("b2b single", {8'd0, bus.reg_r}, 16'h0021);
      tick();
      check("b2b no_restart", {15'd0, bus.refresh_active}, 16'd0);
      refresh_window("b2b second", 8'h02, 8'h21, 8'h22);

      // Instruction start coincident with the 0x22 -> 0x23 increment edge.
      pulse_start(8'h03);
      tick();
      bus.insn_start = 1'b1;
      tick();
      bus.insn_start = 1'b0;
      check("trace reg_r", {8'd0, bus.reg_r}, 16'h0023);
`ifdef Z80FI_TRACE_EN
      check("trace latch", {8'd0, bus.z80fi_reg_r_in}, 16'h0022);
`endif

      // Abort: reset in the first RFSH cycle.
      pulse_start(8'h44);
      check("abort act_pre", {15'd0, bus.refresh_active}, 16'd1);
      reset_n = 1'b0;
      #1;
      check("abort act", {15'd0, bus.refresh_active}, 16'd0);
      check("abort reg_r", {8'd0, bus.reg_r}, 16'h0000);
      check("abort addr", bus.refresh_addr, 16'h0000);
`ifdef Z80FI_TRACE_EN
      check("abort trace", {8'd0, bus.z80fi_reg_r_in}, 16'h0000);
`endif
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      check("abort no_inc", {8'd0, bus.reg_r}, 16'h0000);
      check("abort idle", {15'd0, bus.refresh_active}, 16'd0);
      refresh_window("post_rst", 8'h9A, 8'h00, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
